// File: rtl/img_dmem_reader.sv
// img_dmem_reader: reads one stored frame from the image DMEM and streams it out as
// 16-bit pixels under valid/ready. Each 256-bit DMEM word holds 16 pixels, with lane 0
// in bits [15:0]. Start-of-frame, end-of-row and end-of-frame markers go with the pixels.
// Build option: define IMG_RD_PREFETCH_EN to add a shadow word buffer. The next word is
// then fetched while the current word streams, so there is no gap between words.
module img_dmem_reader #(
    parameter int unsigned NUM_PIX   = 784,
    parameter int unsigned ROW_LEN   = 28,
    parameter logic [6:0]  BASE_ADDR = 7'd0
) (
    input  logic         pxlclk,
    input  logic         rst_n,
    input  logic         iStart,
    input  logic         iAbort,
    output logic         oBusy,
    output logic         oDmem_rden,
    output logic [6:0]   oDmem_addr,
    input  logic [255:0] iDmem_q,
    output logic         oPix_valid,
    input  logic         iPix_ready,
    output logic [15:0]  oPix_data,
    output logic         oPix_sof,
    output logic         oPix_eol,
    output logic         oPix_eof,
    output logic         oDone
);

    localparam logic [9:0] LAST_PIX = 10'(NUM_PIX - 1);
    localparam logic [4:0] LAST_COL = 5'(ROW_LEN - 1);

    typedef enum logic [2:0] {StIdle, StFetch, StWait, StStream, StDone} state_e;

    state_e         state_q;
    logic [9:0]     pix_cnt_q;
    logic [5:0]     word_idx_q;
    logic [3:0]     lane_q;
    logic [4:0]     col_q;
    logic [255:0]   word_buf_q;
    logic           xfer;

`ifdef IMG_RD_PREFETCH_EN
    localparam logic [5:0] LAST_WORD = 6'(NUM_PIX / 16 - 1);

    logic [255:0]   shadow_q;
    logic           shadow_full_q;
    logic           pf_issue_q;     // prefetch read request is on the DMEM port this cycle
    logic           pf_wait_q;      // prefetch data arrives on iDmem_q this cycle
`endif

    assign xfer = (state_q == StStream) && iPix_ready;

    // Frame FSM: sequences word fetches, buffer loads and the pixel counters
    always_ff @(posedge pxlclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            pix_cnt_q     <= '0;
            word_idx_q    <= '0;
            lane_q        <= '0;
            col_q         <= '0;
            word_buf_q    <= '0;
`ifdef IMG_RD_PREFETCH_EN
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            pf_issue_q    <= 1'b0;
            pf_wait_q     <= 1'b0;
`endif
        end else if (iAbort) begin
            // Abort beats every other transition, including a start in IDLE
            state_q       <= StIdle;
            pix_cnt_q     <= '0;
            word_idx_q    <= '0;
            lane_q        <= '0;
            col_q         <= '0;
`ifdef IMG_RD_PREFETCH_EN
            shadow_full_q <= 1'b0;
            pf_issue_q    <= 1'b0;
            pf_wait_q     <= 1'b0;
`endif
        end else begin
`ifdef IMG_RD_PREFETCH_EN
            pf_issue_q <= 1'b0;
            pf_wait_q  <= pf_issue_q;
`endif
            unique case (state_q)
                StIdle: begin
                    if (iStart) begin
                        state_q    <= StFetch;
                        pix_cnt_q  <= '0;
                        word_idx_q <= '0;
                        lane_q     <= '0;
                        col_q      <= '0;
                    end
                end
                StFetch: begin
                    state_q <= StWait;
                end
                StWait: begin
                    word_buf_q <= iDmem_q;
                    lane_q     <= '0;
                    state_q    <= StStream;
`ifdef IMG_RD_PREFETCH_EN
                    pf_issue_q <= (word_idx_q != LAST_WORD) && !shadow_full_q;
`endif
                end
                StStream: begin
                    if (xfer) begin
                        pix_cnt_q <= pix_cnt_q + 10'd1;
                        lane_q    <= lane_q + 4'd1;
                        col_q     <= (col_q == LAST_COL) ? 5'd0 : col_q + 5'd1;
                        if (pix_cnt_q == LAST_PIX) begin
                            state_q <= StDone;
                        end else if (lane_q == 4'd15) begin
                            word_idx_q <= word_idx_q + 6'd1;
`ifdef IMG_RD_PREFETCH_EN
                            if (shadow_full_q) begin
                                // Swap in the prefetched word and start fetching the one after
                                word_buf_q    <= shadow_q;
                                shadow_full_q <= 1'b0;
                                pf_issue_q    <= (word_idx_q + 6'd1) != LAST_WORD;
                            end else begin
                                state_q <= StFetch;
                            end
`else
                            state_q <= StFetch;
`endif
                        end
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
`ifdef IMG_RD_PREFETCH_EN
            // A read is only issued with the shadow empty, so this never overwrites a full shadow
            if (pf_wait_q) begin
                shadow_q      <= iDmem_q;
                shadow_full_q <= 1'b1;
            end
`endif
        end
    end

    // Outputs decoded from the registered state and counters
    always_comb begin
        oBusy      = (state_q != StIdle);
        oPix_valid = (state_q == StStream);
        oDone      = (state_q == StDone);
        oPix_data  = oPix_valid ? word_buf_q[{lane_q, 4'b0000} +: 16] : 16'd0;
        oPix_sof   = oPix_valid && (pix_cnt_q == 10'd0);
        oPix_eol   = oPix_valid && (col_q == LAST_COL);
        oPix_eof   = oPix_valid && (pix_cnt_q == LAST_PIX);
        oDmem_rden = (state_q == StFetch);
        oDmem_addr = (state_q == StFetch) ? BASE_ADDR + {1'b0, word_idx_q} : 7'd0;
`ifdef IMG_RD_PREFETCH_EN
        if (pf_issue_q) begin
            oDmem_rden = 1'b1;
            oDmem_addr = BASE_ADDR + {1'b0, word_idx_q} + 7'd1;
        end
`endif
    end

endmodule
